// File: rtl/qc_pkg.sv
// Shared definitions for the quantum-circuit datapath blocks:
// fixed-point helpers, LFSR constants and the measurement FSM states.
package qc_pkg;

    // Sign-magnitude word of width n: fraction bits below the sign bit.
    function automatic int unsigned frac_bits(input int unsigned n);
        return n - 1;
    endfunction

    function automatic int unsigned sign_bit(input int unsigned n);
        return n - 1;
    endfunction

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form:
    // feedback is the XOR of state bits 0, 2, 3 and 5, entering at bit 15.
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] LFSR_NZ_SEED  = 16'h0001;

    typedef enum logic [1:0] {
        IDLE,
        SQUARE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR; loads seed on reset and steps only when enabled.
module lfsr16
    import qc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic fb;

    assign fb = ^(state & LFSR_TAPS);

    // State register: an all-zero seed would lock up, so substitute 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (seed == '0) ? LFSR_NZ_SEED : seed;
        end else if (en) begin
            state <= {fb, state[15:1]};
        end
    end

endmodule

// File: rtl/measure_1qb.sv
// Single-qubit measurement: squares the amplitudes into basis probabilities,
// then runs num_shots Bernoulli trials against p1 and reports outcome counts.
module measure_1qb
    import qc_pkg::*;
#(
    parameter int          N       = 16,
    parameter int          SHOTS_W = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       state_vec [4],
    input  logic [SHOTS_W-1:0] num_shots,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       prob0,
    output logic [N-1:0]       prob1,
    output logic [SHOTS_W-1:0] count0,
    output logic [SHOTS_W-1:0] count1
);

    localparam int unsigned FB    = frac_bits(N);
    localparam int unsigned SB    = sign_bit(N);
    localparam logic [N-1:0] P_MAX = ~(N'(1) << SB);

    state_t               state_q, state_d;
    logic [N-1:0]         vec_q [4];
    logic [SHOTS_W-1:0]   shots_q;
    logic [SHOTS_W-1:0]   shot_cnt;
    logic [15:0]          lfsr_state;

    logic [FB-1:0]        mag  [4];
    logic [2*FB-1:0]      prod [4];
    logic [FB-1:0]        sq   [4];
    logic [N-1:0]         sum0, sum1, p0_sat, p1_sat;
    logic [FB-1:0]        r;
    logic                 shot_one;
    logic                 last_shot;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == SAMPLE),
        .seed  (SEED),
        .state (lfsr_state)
    );

    // Magnitude squares (sign dropped, so -0 squares to 0) and saturated sums.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            mag[i]  = FB'(vec_q[i]);
            prod[i] = {{FB{1'b0}}, mag[i]} * {{FB{1'b0}}, mag[i]};
            sq[i]   = FB'(prod[i] >> FB);
        end
        sum0   = {1'b0, sq[0]} + {1'b0, sq[1]};
        sum1   = {1'b0, sq[2]} + {1'b0, sq[3]};
        p0_sat = (sum0 > P_MAX) ? P_MAX : sum0;
        p1_sat = (sum1 > P_MAX) ? P_MAX : sum1;
    end

    // Shot decision: a saturated p1 always yields 1, otherwise compare r < p1.
    always_comb begin
        r         = FB'(lfsr_state >> (16 - FB));
        shot_one  = ({1'b0, r} < prob1) || (prob1 == P_MAX);
        last_shot = (shot_cnt == shots_q - SHOTS_W'(1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SQUARE;
            end
            SQUARE: state_d = (shots_q == '0) ? DONE : SAMPLE;
            SAMPLE: if (last_shot) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: job capture, probability registers and outcome counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '{default: '0};
            shots_q  <= '0;
            shot_cnt <= '0;
            prob0    <= '0;
            prob1    <= '0;
            count0   <= '0;
            count1   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        vec_q   <= state_vec;
                        shots_q <= num_shots;
                    end
                end
                SQUARE: begin
                    prob0    <= p0_sat;
                    prob1    <= p1_sat;
                    count0   <= '0;
                    count1   <= '0;
                    shot_cnt <= '0;
                end
                SAMPLE: begin
                    shot_cnt <= shot_cnt + SHOTS_W'(1);
                    if (shot_one) count1 <= count1 + SHOTS_W'(1);
                    else          count0 <= count0 + SHOTS_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_measure_1qb.sv
// Self-checking bench for measure_1qb: directed cases plus random jobs,
// compared against an arithmetic reference model of the measurement.
module tb_measure_1qb;

    localparam int          N    = 16;
    localparam int          SW   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  state_vec [4];
    logic [SW-1:0] num_shots;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  prob0, prob1;
    logic [SW-1:0] count0, count1;

    measure_1qb #(.N(N), .SHOTS_W(SW), .SEED(SEED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_vec (state_vec),
        .num_shots (num_shots),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prob0     (prob0),
        .prob1     (prob1),
        .count0    (count0),
        .count1    (count1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic [15:0] jv [4];
    int exp_p0, exp_p1, exp_c0, exp_c1;

    function automatic int sq_of(input logic [15:0] w);
        int m;
        m = int'(w[14:0]);
        return (m * m) / 32768;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        int x, b;
        x = int'(l);
        b = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
        return 16'((x >> 1) | (b << 15));
    endfunction

    task automatic model_job(input int shots);
        int r;
        exp_p0 = sq_of(jv[0]) + sq_of(jv[1]);
        exp_p1 = sq_of(jv[2]) + sq_of(jv[3]);
        if (exp_p0 > 32767) exp_p0 = 32767;
        if (exp_p1 > 32767) exp_p1 = 32767;
        exp_c0 = 0;
        exp_c1 = 0;
        for (int i = 0; i < shots; i++) begin
            r = int'(m_lfsr) / 2;
            if (r < exp_p1 || exp_p1 == 32767) exp_c1++;
            else                               exp_c0++;
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // ---------------- job driver ----------------
    task automatic run_job(input int shots, input int hold, input bit early);
        int w, cyc;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check_val("idle_ready", 32'(in_ready), 32'd1);
        model_job(shots);
        state_vec = jv;
        num_shots = SW'(shots);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) state_vec[i] = 16'($urandom);
        num_shots = 16'($urandom);
        if (early) out_ready = 1'b1;
        check_val("busy_ready", 32'(in_ready), 32'd0);
        cyc = 1;
        while (!out_valid && cyc < shots + 20) begin
            in_valid = 1'($urandom);
            @(posedge clk); #1; cyc++;
        end
        in_valid = 1'b0;
        check_val("latency", 32'(cyc), 32'(shots + 2));
        check_val("prob0", 32'(prob0), 32'(exp_p0));
        check_val("prob1", 32'(prob1), 32'(exp_p1));
        check_val("count0", 32'(count0), 32'(exp_c0));
        check_val("count1", 32'(count1), 32'(exp_c1));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'($urandom);
                @(posedge clk); #1;
                check_val("hold_valid", 32'(out_valid), 32'd1);
                check_val("hold_ready", 32'(in_ready), 32'd0);
                check_val("hold_c1", 32'(count1), 32'(exp_c1));
                check_val("hold_p0", 32'(prob0), 32'(exp_p0));
            end
        end
        // Release with in_valid still high: it must not be taken in DONE.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("release_ready", 32'(in_ready), 32'd1);
        check_val("release_valid", 32'(out_valid), 32'd0);
    endtask

    int s_c0, s_c1;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num_shots = '0;
        for (int i = 0; i < 4; i++) state_vec[i] = '0;
        m_lfsr = SEED;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_outs", 32'(prob0 | prob1 | count0 | count1), 32'd0);
        rst_n = 1'b1;

        // Mixed amplitudes, first job after reset; remembered for the repro.
        jv = '{16'h4000, 16'h2000, 16'h6000, 16'h1000};
        run_job(100, 0, 1'b0);
        s_c0 = exp_c0;
        s_c1 = exp_c1;

        // |0>
        jv = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
        run_job(100, 0, 1'b0);
        check_val("ket0_p0", 32'(prob0), 32'h7FFE);
        check_val("ket0_c0", 32'(count0), 32'd100);

        // |1> with saturation (negative re1)
        jv = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0100};
        run_job(50, 0, 1'b1);
        check_val("ket1_p1", 32'(prob1), 32'h7FFF);
        check_val("ket1_c1", 32'(count1), 32'd50);

        // Equal superposition, negative zero in the imaginary parts
        jv = '{16'h5A82, 16'h8000, 16'h5A82, 16'h8000};
        run_job(4096, 0, 1'b0);
        check_val("sup_p0", 32'(prob0), 32'h3FFF);
        check_val("sup_p1", 32'(prob1), 32'h3FFF);
        check_val("sup_range", 32'(count1 >= 16'd1848 && count1 <= 16'd2248), 32'd1);
        check_val("sup_sum", 32'(count0) + 32'(count1), 32'd4096);

        // Zero shots, with backpressure in DONE
        jv = '{16'h1234, 16'hC321, 16'h7000, 16'h0042};
        run_job(0, 5, 1'b0);

        // Abort at shot 10 of 100 with a reset
        jv = '{16'h4000, 16'h2000, 16'h6000, 16'h1000};
        state_vec = jv;
        num_shots = 16'd100;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check_val("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("abort_ready", 32'(in_ready), 32'd1);
        check_val("abort_valid", 32'(out_valid), 32'd0);
        check_val("abort_outs", 32'(prob0 | prob1 | count0 | count1), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        m_lfsr = SEED;
        run_job(100, 0, 1'b0);
        check_val("repro_c0", 32'(count0), 32'(s_c0));
        check_val("repro_c1", 32'(count1), 32'(s_c1));

        // Random jobs
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 4; i++) jv[i] = 16'($urandom);
            run_job(int'($urandom_range(0, 300)), int'($urandom_range(0, 5)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
